mssb_test_seq: RTL and testbench
================================

Name: mssb_test_seq

Overview:
- OPB initiator that runs one MSSB link self-test through the MSSB test interface's register map without software.
- On START it programs the transfer length and sets the start bit, then polls status and received-byte count until done or timeout, then reads the error count.
- It reports PASS/FAIL, the result code and both counts on flat outputs, for a front-panel LED or a debug register.
- It sits beside the MSSB test interface and shares its OPB address/data/strobe nets through the board-level OPB mux.

Parameters:
- POLL_INTERVAL, 100000, OPB_CLK cycles between poll rounds (1 ms at 100 MHz).
- TIMEOUT_POLLS, 20000, poll rounds before the run is declared timed out (~20 s).
- MAX_TRANSMIT_BYTES, 20'hF4240, upper clamp on the requested length (1M bytes).

Ports:
- OPB_CLK  in  1  100 MHz clock.
- OPB_RST_N  in  1  reset: synchronous, active-low.
- START  in  1  1-cycle pulse; ignored unless idle.
- ABORT  in  1  synchronous abort; returns to idle.
- TRANS_BYTES  in  20  requested byte count, sampled on START.
- OPB_ADDR  out  32  register address; only [3:0] non-zero.
- OPB_DO  out  32  write data.
- OPB_DI  in  32  read data from target, registered (valid the cycle after RE).
- MSSB_IF_WE  out  1  write strobe, 1 cycle.
- MSSB_IF_RE  out  1  read strobe, 1 cycle.
- BUSY  out  1  high from START accept until REPORT.
- DONE  out  1  1-cycle pulse in REPORT.
- PASS  out  1  valid from DONE until next START.
- RESULT  out  2  00 pass, 01 data error, 10 timeout, 11 config error.
- RECV_BYTES  out  20  last captured received count.
- ERROR_BYTES  out  20  last captured error count.

Behaviour:
- Reset (OPB_RST_N=0 at a clock edge): every output 0, FSM in IDLE, counters 0. Reset mid-run abandons the run with no further bus cycle.
- Register map: 0 config {[31] start, [19:0] bytes}; 1 status {[0] done, [1] error}; 2 received bytes; 3 error bytes.
- States: IDLE, WR_CFG, WAIT, RD_ST, CAP_ST, RD_RX, CAP_RX, RD_ERR, CAP_ERR, REPORT.
- IDLE: on START, latch len = min(TRANS_BYTES, MAX_TRANSMIT_BYTES) and clear the poll count.
  - If TRANS_BYTES==0, go directly to REPORT with RESULT=11 and no bus cycle.
  - Otherwise go to WR_CFG.
- WR_CFG: one cycle with WE=1, ADDR=0, DO={1'b1,11'b0,len}, then WAIT. Outside WR_CFG, DO=0 and WE=0.
- WAIT: count POLL_INTERVAL cycles, then RD_ST.
- RD_ST / RD_RX / RD_ERR: one cycle with RE=1 at address 1 / 2 / 3. RE and WE are never high together. ADDR returns to 0 outside read/write states.
- CAP_x: capture OPB_DI in the cycle after RD_x, then advance.
- After CAP_RX, increment the poll count and decide:
  - If status[0]==1 and rx>=len, go to RD_ERR. The status done bit can remain set from a previous run, so completion always also requires rx>=len.
  - Else if the poll count == TIMEOUT_POLLS, go to RD_ERR with the timeout flag set.
  - Else go to WAIT.
- CAP_ERR then REPORT. RESULT priority: timeout → 10; else status[1] or err!=0 → 01; else 00. PASS = (RESULT==00).
- REPORT: DONE=1 for one cycle; BUSY drops in the same cycle; then IDLE. RECV_BYTES/ERROR_BYTES hold until the next accepted START.
- START while BUSY: ignored.
- ABORT: highest priority after reset. Next state IDLE, no DONE, RESULT/PASS unchanged, in-flight strobes deasserted the next cycle.
- Poll counter width: clog2(TIMEOUT_POLLS+1). Interval counter width: clog2(POLL_INTERVAL). Neither wraps; both clear on START.

Decomposition:
- Shared package mssb_pkg:
  - register addresses ADDR_MSSB_CONFIG/STATUS/RECV_BYTES/ERROR_BYTES;
  - RESULT encodings;
  - state enum;
  - MAX/MIN_TRANSMIT_BYTES.
- One natural sub-module, mssb_opb_master_port: it turns a 1-cycle request (rd/wr, addr, wdata) into the strobes and returns rdata_valid one cycle after RE. The FSM stays in the top.

Test Plan:
- Responder model returns status=1, rx=len, err=0 after 3 polls; START with TRANS_BYTES=10000 → one write ADDR=0 DO=0x80002710, 3 rounds of status/rx reads 100000 cycles apart, read of ADDR 3, DONE, PASS=1, RESULT=00, RECV_BYTES=10000.
- Model returns status=3 and err=5 → RESULT=01, PASS=0, ERROR_BYTES=5.
- Status stuck at 1 with rx<len, TIMEOUT_POLLS=4 → exactly 4 poll rounds, then error read, RESULT=10.
- TRANS_BYTES=0 → DONE 1 cycle after START, RESULT=11, no WE/RE. TRANS_BYTES=0xFFFFF → DO[19:0]=0xF4240.
- START during a run is ignored. ABORT in WAIT → IDLE, no DONE, no further RE.
- OPB_RST_N low during RD_ST → all outputs 0 on the next edge; a later START runs normally.

Source files
------------

// File: rtl/mssb_pkg.sv
// mssb_pkg: shared register map, result codes, FSM states and length limits for the MSSB self-test
package mssb_pkg;
  localparam logic [3:0] ADDR_MSSB_CONFIG      = 4'd0;
  localparam logic [3:0] ADDR_MSSB_STATUS      = 4'd1;
  localparam logic [3:0] ADDR_MSSB_RECV_BYTES  = 4'd2;
  localparam logic [3:0] ADDR_MSSB_ERROR_BYTES = 4'd3;
  localparam logic [1:0] RES_PASS     = 2'b00;
  localparam logic [1:0] RES_DATA_ERR = 2'b01;
  localparam logic [1:0] RES_TIMEOUT  = 2'b10;
  localparam logic [1:0] RES_CFG_ERR  = 2'b11;
  localparam logic [19:0] MAX_TRANSMIT_BYTES = 20'hF4240;
  localparam logic [19:0] MIN_TRANSMIT_BYTES = 20'd1;
  typedef enum logic [3:0] {
    IDLE, WR_CFG, WAIT, RD_ST, CAP_ST, RD_RX, CAP_RX, RD_ERR, CAP_ERR, REPORT
  } state_t;
endpackage

// File: rtl/mssb_opb_master_port.sv
// mssb_opb_master_port: turns a one-cycle read/write request into OPB strobes and flags returned read data
module mssb_opb_master_port
  import mssb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] opb_addr,
  output logic [31:0] opb_do,
  output logic        we,
  output logic        re,
  input  logic [31:0] opb_di,
  output logic [31:0] rdata,
  output logic        rdata_valid
);
  logic rdata_valid_q, rdata_valid_d;
  // strobes are exclusive and the bus parks at address 0 with zero data between requests
  always_comb begin
    re = rd;
    we = wr & ~rd;
    opb_addr = {28'b0, (rd | wr) ? addr : ADDR_MSSB_CONFIG};
    opb_do = we ? wdata : '0;
    rdata = opb_di;
    rdata_valid = rdata_valid_q;
    rdata_valid_d = rd;
  end
  // target data is registered, so it is valid the cycle after the read strobe
  always_ff @(posedge clk) begin
    if (!rst_n) rdata_valid_q <= 1'b0;
    else rdata_valid_q <= rdata_valid_d;
  end
endmodule

// File: rtl/mssb_test_seq.sv
// mssb_test_seq: autonomous OPB initiator that runs one MSSB link self-test and reports the outcome
module mssb_test_seq #(
  parameter int unsigned POLL_INTERVAL      = 100000,
  parameter int unsigned TIMEOUT_POLLS      = 20000,
  parameter logic [19:0] MAX_TRANSMIT_BYTES = mssb_pkg::MAX_TRANSMIT_BYTES
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic [19:0] TRANS_BYTES,
  output logic [31:0] OPB_ADDR,
  output logic [31:0] OPB_DO,
  input  logic [31:0] OPB_DI,
  output logic        MSSB_IF_WE,
  output logic        MSSB_IF_RE,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [1:0]  RESULT,
  output logic [19:0] RECV_BYTES,
  output logic [19:0] ERROR_BYTES
);
  import mssb_pkg::*;
  localparam int IW = POLL_INTERVAL > 1 ? $clog2(POLL_INTERVAL) : 1;
  localparam int PW = $clog2(TIMEOUT_POLLS + 1);
  state_t state_q, state_d;
  logic [19:0] len_q, len_d, rx_q, rx_d, err_q, err_d;
  logic [IW-1:0] ivl_q, ivl_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [1:0] st_q, st_d, result_q, result_d;
  logic to_q, to_d, pass_q, pass_d;
  logic rd, wr, rd_valid;
  logic [3:0] addr;
  logic [31:0] rdata;
  mssb_opb_master_port u_port (
    .clk(OPB_CLK), .rst_n(OPB_RST_N), .rd(rd), .wr(wr), .addr(addr),
    .wdata({1'b1, 11'b0, len_q}), .opb_addr(OPB_ADDR), .opb_do(OPB_DO),
    .we(MSSB_IF_WE), .re(MSSB_IF_RE), .opb_di(OPB_DI), .rdata(rdata),
    .rdata_valid(rd_valid)
  );
  assign PASS = pass_q;
  assign RESULT = result_q;
  assign RECV_BYTES = rx_q;
  assign ERROR_BYTES = err_q;
  // state and datapath registers; reset abandons any run in flight
  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      state_q <= IDLE;
      len_q <= '0;
      rx_q <= '0;
      err_q <= '0;
      ivl_q <= '0;
      poll_q <= '0;
      st_q <= '0;
      result_q <= '0;
      to_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      rx_q <= rx_d;
      err_q <= err_d;
      ivl_q <= ivl_d;
      poll_q <= poll_d;
      st_q <= st_d;
      result_q <= result_d;
      to_q <= to_d;
      pass_q <= pass_d;
    end
  end
  // next state: abort wins, a completed run needs both the done bit and enough received bytes
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    rx_d = rx_q;
    err_d = err_q;
    ivl_d = ivl_q;
    poll_d = poll_q;
    st_d = st_q;
    result_d = result_q;
    to_d = to_q;
    pass_d = pass_q;
    if (ABORT) state_d = IDLE;
    else case (state_q)
      IDLE: if (START) begin
        len_d = TRANS_BYTES > MAX_TRANSMIT_BYTES ? MAX_TRANSMIT_BYTES : TRANS_BYTES;
        rx_d = '0;
        err_d = '0;
        ivl_d = '0;
        poll_d = '0;
        st_d = '0;
        to_d = 1'b0;
        if (TRANS_BYTES < MIN_TRANSMIT_BYTES) begin
          result_d = RES_CFG_ERR;
          pass_d = 1'b0;
          state_d = REPORT;
        end else state_d = WR_CFG;
      end
      WR_CFG: state_d = WAIT;
      WAIT: begin
        ivl_d = ivl_q + IW'(1);
        if (ivl_q == IW'(POLL_INTERVAL - 1)) begin
          ivl_d = '0;
          state_d = RD_ST;
        end
      end
      RD_ST: state_d = CAP_ST;
      CAP_ST: if (rd_valid) begin
        st_d = rdata[1:0];
        state_d = RD_RX;
      end
      RD_RX: state_d = CAP_RX;
      CAP_RX: if (rd_valid) begin
        rx_d = rdata[19:0];
        poll_d = poll_q + PW'(1);
        if (st_q[0] && rdata >= {12'b0, len_q}) state_d = RD_ERR;
        else if (poll_d == PW'(TIMEOUT_POLLS)) begin
          to_d = 1'b1;
          state_d = RD_ERR;
        end else state_d = WAIT;
      end
      RD_ERR: state_d = CAP_ERR;
      CAP_ERR: if (rd_valid) begin
        err_d = rdata[19:0];
        result_d = to_q ? RES_TIMEOUT : (st_q[1] || rdata != '0) ? RES_DATA_ERR : RES_PASS;
        pass_d = !to_q && !st_q[1] && rdata == '0;
        state_d = REPORT;
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // bus requests and handshake outputs decoded from the current state
  always_comb begin
    wr = state_q == WR_CFG;
    rd = state_q inside {RD_ST, RD_RX, RD_ERR};
    addr = state_q == RD_ST ? ADDR_MSSB_STATUS :
           state_q == RD_RX ? ADDR_MSSB_RECV_BYTES :
           state_q == RD_ERR ? ADDR_MSSB_ERROR_BYTES : ADDR_MSSB_CONFIG;
    BUSY = state_q != IDLE && state_q != REPORT;
    DONE = state_q == REPORT;
  end
endmodule

// File: tb/tb_mssb_test_seq.sv
// tb_mssb_test_seq: scoreboard bench with an MSSB register responder and directed self-test runs
module tb_mssb_test_seq;
  localparam int PI = 16;
  localparam int TP = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [19:0] tbytes = '0;
  logic [31:0] di = '0;
  logic [31:0] addr_o, do_o;
  logic we, re, busy, done, pass;
  logic [1:0] result;
  logic [19:0] recv, errb;

  always #5 clk = ~clk;

  mssb_test_seq #(.POLL_INTERVAL(PI), .TIMEOUT_POLLS(TP)) dut (
    .OPB_CLK(clk), .OPB_RST_N(rst_n), .START(start), .ABORT(abort), .TRANS_BYTES(tbytes),
    .OPB_ADDR(addr_o), .OPB_DO(do_o), .OPB_DI(di), .MSSB_IF_WE(we), .MSSB_IF_RE(re),
    .BUSY(busy), .DONE(done), .PASS(pass), .RESULT(result), .RECV_BYTES(recv), .ERROR_BYTES(errb)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [1:0]  res;
    logic        pass;
    logic [19:0] rx;
    logic [19:0] err;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_st = -1, n_wait = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [3:0] a, input logic [31:0] d,
                      input logic [1:0] r, input logic p, input logic [19:0] rx, input logic [19:0] er);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.res = r; e.pass = p; e.rx = rx; e.err = er;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] d);
    push(2'd1, 4'd0, d, 2'd0, 1'b0, 20'd0, 20'd0);
  endtask

  task automatic push_rd(input logic [3:0] a);
    push(2'd2, a, 32'd0, 2'd0, 1'b0, 20'd0, 20'd0);
  endtask

  task automatic push_rounds(input int n);
    for (int i = 0; i < n; i++) begin
      push_rd(4'd1);
      push_rd(4'd2);
    end
  endtask

  task automatic push_done(input logic [1:0] r, input logic p, input logic [19:0] rx, input logic [19:0] er);
    push(2'd3, 4'd0, 32'd0, r, p, rx, er);
  endtask

  task automatic pulse_start(input logic [19:0] b);
    @(posedge clk); #1;
    tbytes = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_empty(input int budget, input string nm);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending events expected 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // MSSB target model: mode 0 completes on the 3rd poll, mode 1 reports errors, mode 2 never receives enough
  int mode = 0;
  int k = 0;
  logic [19:0] rlen = '0;
  always @(posedge clk) begin
    if (we) begin
      k <= 0;
      rlen <= do_o[19:0];
    end
    if (re) begin
      case (addr_o[3:0])
        4'd1: begin
          k <= k + 1;
          di <= mode == 0 ? ((k + 1 >= 3) ? 32'd1 : 32'd0) : mode == 1 ? 32'd3 : 32'd1;
        end
        4'd2: di <= mode == 0 ? ((k >= 3) ? {12'b0, rlen} : 32'd0) :
                    mode == 1 ? {12'b0, rlen} : {12'b0, rlen - 20'd1};
        4'd3: di <= mode == 1 ? 32'd5 : 32'd0;
        default: di <= 32'd0;
      endcase
    end
  end

  // monitor: every strobe or DONE pops one expected event
  always @(negedge clk) begin
    cyc++;
    if (we || re) chk("we_re_exclusive", {31'b0, we & re}, 32'd0);
    else begin
      chk("idle_addr", addr_o, 32'd0);
      chk("idle_do", do_o, 32'd0);
    end
    if (we || re || done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got we=%0b re=%0b done=%0b addr=%0h expected none", we, re, done, addr_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_kind", we ? 32'd1 : re ? 32'd2 : 32'd3, {30'b0, mon_e.kind});
        if (we) begin
          chk("wr_addr", addr_o, {28'b0, mon_e.addr});
          chk("wr_data", do_o, mon_e.data);
          last_st = -1;
        end else if (re) begin
          chk("rd_addr", addr_o, {28'b0, mon_e.addr});
          if (addr_o == 32'd1) begin
            if (last_st >= 0) chk("poll_spacing", 32'(cyc - last_st), 32'(PI + 4));
            last_st = cyc;
          end
        end else begin
          chk("done_result", {30'b0, result}, {30'b0, mon_e.res});
          chk("done_pass", {31'b0, pass}, {31'b0, mon_e.pass});
          chk("done_recv", {12'b0, recv}, {12'b0, mon_e.rx});
          chk("done_err", {12'b0, errb}, {12'b0, mon_e.err});
          chk("done_busy", {31'b0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, {31'b0, busy}, 32'd0);
    chk({nm, "_done"}, {31'b0, done}, 32'd0);
    chk({nm, "_pass"}, {31'b0, pass}, 32'd0);
    chk({nm, "_result"}, {30'b0, result}, 32'd0);
    chk({nm, "_recv"}, {12'b0, recv}, 32'd0);
    chk({nm, "_err"}, {12'b0, errb}, 32'd0);
    chk({nm, "_we_re"}, {30'b0, we, re}, 32'd0);
    chk({nm, "_addr"}, addr_o, 32'd0);
    chk({nm, "_do"}, do_o, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    // normal pass after three polls
    mode = 0;
    push_wr(32'h80002710); push_rounds(3); push_rd(4'd3); push_done(2'b00, 1'b1, 20'd10000, 20'd0);
    pulse_start(20'd10000);
    wait_empty(300, "run_pass");
    chk("pass_hold", {31'b0, pass}, 32'd1);
    chk("recv_hold", {12'b0, recv}, 32'd10000);
    // data error reported by status and error count
    mode = 1;
    push_wr(32'h8000012C); push_rounds(1); push_rd(4'd3); push_done(2'b01, 1'b0, 20'd300, 20'd5);
    pulse_start(20'd300);
    wait_empty(300, "run_data_err");
    chk("err_hold", {12'b0, errb}, 32'd5);
    // timeout: done bit set but received count short
    mode = 2;
    push_wr(32'h80000032); push_rounds(TP); push_rd(4'd3); push_done(2'b10, 1'b0, 20'd49, 20'd0);
    pulse_start(20'd50);
    wait_empty(300, "run_timeout");
    // zero length: config error with no bus cycle
    push_done(2'b11, 1'b0, 20'd0, 20'd0);
    pulse_start(20'd0);
    chk("zero_done_next_cycle", {31'b0, done}, 32'd1);
    chk("zero_result", {30'b0, result}, 32'd3);
    wait_empty(20, "run_zero");
    // oversize length clamps; a second START mid-run is ignored
    mode = 0;
    push_wr(32'h800F4240); push_rounds(3); push_rd(4'd3); push_done(2'b00, 1'b1, 20'hF4240, 20'd0);
    pulse_start(20'hFFFFF);
    repeat (4) @(posedge clk);
    #1;
    tbytes = 20'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_ignores_start", {31'b0, busy}, 32'd1);
    wait_empty(300, "run_clamp");
    // abort while waiting between polls
    push_wr(32'h80000014);
    pulse_start(20'd20);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (60) @(posedge clk);
    #1;
    chk("abort_pending", 32'(exp_q.size()), 32'd0);
    chk("abort_result_kept", {30'b0, result}, 32'd0);
    chk("abort_pass_kept", {31'b0, pass}, 32'd1);
    exp_q.delete();
    // reset while the status read is on the bus
    push_wr(32'h80000014); push_rd(4'd1);
    pulse_start(20'd20);
    n_wait = 0;
    while (!(re && addr_o == 32'd1) && n_wait < 100) begin
      @(posedge clk); #1;
      n_wait++;
    end
    chk("reach_rd_st", {31'b0, re && addr_o == 32'd1}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    // normal run after reset
    mode = 0;
    push_wr(32'h80002710); push_rounds(3); push_rd(4'd3); push_done(2'b00, 1'b1, 20'd10000, 20'd0);
    pulse_start(20'd10000);
    wait_empty(300, "run_after_reset");
    chk("final_pass", {31'b0, pass}, 32'd1);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
